// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the pooling controller: FSM state encoding, pooling
// mode encoding and the default coordinate width.
// -----------------------------------------------------------------------------
package pool_pkg;

   // Default width of row/column window coordinates.
   localparam int unsigned COORD_W_DEFAULT = 8;

   // Pooling mode encoding as seen on cfg_mode / ctrl_pool.
   localparam logic MODE_AVG = 1'b0;
   localparam logic MODE_MAX = 1'b1;

   // Controller states.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } pool_state_e;

endpackage

// File: rtl/pool_win_counter.sv
// -----------------------------------------------------------------------------
// pool_win_counter
// Raster-order window counter: col is the inner loop (0..cols_lim-1), row the
// outer loop (0..rows_lim-1). 'last' flags the final window (rows-1, cols-1).
// Stepping past the final window wraps back to (0,0).
//
// Ports
//   clk       in   clock, rising edge
//   nrst      in   synchronous active-low reset
//   clear     in   force the count back to (0,0)
//   step      in   advance one window in raster order
//   rows_lim  in   number of window rows
//   cols_lim  in   number of window columns
//   row       out  current window row
//   col       out  current window column
//   last      out  current window is the final one of the map
// -----------------------------------------------------------------------------
module pool_win_counter #(
   parameter int unsigned COORD_W = 8
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               clear,
   input  logic               step,
   input  logic [COORD_W-1:0] rows_lim,
   input  logic [COORD_W-1:0] cols_lim,
   output logic [COORD_W-1:0] row,
   output logic [COORD_W-1:0] col,
   output logic               last
);

   localparam logic [COORD_W-1:0] CoordOne = COORD_W'(1);

   logic [COORD_W-1:0] row_q, row_d;
   logic [COORD_W-1:0] col_q, col_d;
   logic               last_col;

   assign last_col = (col_q == (cols_lim - CoordOne));
   assign last     = last_col && (row_q == (rows_lim - CoordOne));

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear) begin
         row_d = '0;
         col_d = '0;
      end else if (step) begin
         if (last_col) begin
            col_d = '0;
            row_d = last ? '0 : (row_q + CoordOne);
         end else begin
            col_d = col_q + CoordOne;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row = row_q;
   assign col = col_q;

endmodule

// File: rtl/pooling_ctrl.sv
// -----------------------------------------------------------------------------
// pooling_ctrl
// Sequences one feature-map pooling operation: issues one window read per
// unstalled cycle in raster order, tracks the three-stage datapath with valid
// bits v1 (buffer output), v2 (datapath input reg) and v3 (datapath output
// reg), and hands results downstream with a valid/ready handshake. A result
// that is not accepted freezes the whole pipe, including the read counter.
//
// Ports
//   clk            in   clock, rising edge
//   nrst           in   synchronous active-low reset
//   start          in   pulse to begin an operation (sampled in IDLE only)
//   cfg_mode       in   1 = max pooling, 0 = average (latched at start)
//   cfg_out_rows   in   output map height in windows (latched at start)
//   cfg_out_cols   in   output map width in windows (latched at start)
//   rd_en          out  read one window from the input window buffer
//   rd_row/rd_col  out  coordinate of the current read
//   in_pipe_en     out  load the datapath input register
//   out_pipe_en    out  load the datapath output register
//   ctrl_pool      out  pooling mode for the datapath
//   wr_valid       out  datapath output register holds a result
//   wr_ready       in   downstream accepts the result
//   wr_row/wr_col  out  coordinate of the result in the output register
//   busy           out  operation in progress (RUN or DRAIN)
//   done           out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module pooling_ctrl
   import pool_pkg::*;
#(
   parameter int unsigned COORD_W = COORD_W_DEFAULT
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               start,
   input  logic               cfg_mode,
   input  logic [COORD_W-1:0] cfg_out_rows,
   input  logic [COORD_W-1:0] cfg_out_cols,
   output logic               rd_en,
   output logic [COORD_W-1:0] rd_row,
   output logic [COORD_W-1:0] rd_col,
   output logic               in_pipe_en,
   output logic               out_pipe_en,
   output logic               ctrl_pool,
   output logic               wr_valid,
   input  logic               wr_ready,
   output logic [COORD_W-1:0] wr_row,
   output logic [COORD_W-1:0] wr_col,
   output logic               busy,
   output logic               done
);

   pool_state_e        state_q, state_d;

   // Latched configuration.
   logic               mode_q;
   logic [COORD_W-1:0] rows_q;
   logic [COORD_W-1:0] cols_q;

   // Valid bits and coordinates travelling with each pipeline stage.
   logic               v1_q, v2_q, v3_q;
   logic [COORD_W-1:0] r1_q, c1_q, r2_q, c2_q, r3_q, c3_q;

   logic               stall;
   logic               rd_fire;
   logic               start_ok;
   logic               zero_dim;
   logic               last_handshake;

   logic [COORD_W-1:0] win_row;
   logic [COORD_W-1:0] win_col;
   logic               win_last;

   // A held result blocks every stage, since there is no skid storage.
   assign stall    = v3_q & ~wr_ready;
   assign rd_fire  = (state_q == StRun) & ~stall;
   assign start_ok = (state_q == StIdle) & start;
   assign zero_dim = (cfg_out_rows == '0) || (cfg_out_cols == '0);

   // Final result leaves only when nothing is behind it in the pipe.
   assign last_handshake = v3_q & wr_ready & ~v1_q & ~v2_q;

   // Counter stays at (0,0) outside RUN so each run starts clean.
   pool_win_counter #(
      .COORD_W (COORD_W)
   ) u_win_counter (
      .clk      (clk),
      .nrst     (nrst),
      .clear    (state_q != StRun),
      .step     (rd_fire),
      .rows_lim (rows_q),
      .cols_lim (cols_q),
      .row      (win_row),
      .col      (win_col),
      .last     (win_last)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = zero_dim ? StDone : StRun;
            end
         end
         StRun: begin
            if (rd_fire && win_last) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (last_handshake) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= StIdle;
         mode_q  <= MODE_AVG;
         rows_q  <= '0;
         cols_q  <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         r1_q    <= '0;
         c1_q    <= '0;
         r2_q    <= '0;
         c2_q    <= '0;
         r3_q    <= '0;
         c3_q    <= '0;
      end else begin
         state_q <= state_d;

         if (start_ok) begin
            mode_q <= cfg_mode;
            rows_q <= cfg_out_rows;
            cols_q <= cfg_out_cols;
         end

         if (!stall) begin
            v1_q <= rd_fire;
            v2_q <= v1_q;
            v3_q <= v2_q;
            r1_q <= win_row;
            c1_q <= win_col;
            r2_q <= r1_q;
            c2_q <= c1_q;
            r3_q <= r2_q;
            c3_q <= c2_q;
         end
      end
   end

   assign rd_en       = rd_fire;
   assign rd_row      = win_row;
   assign rd_col      = win_col;
   assign in_pipe_en  = v1_q & ~stall;
   assign out_pipe_en = v2_q & ~stall;
   assign wr_valid    = v3_q;
   assign wr_row      = r3_q;
   assign wr_col      = c3_q;
   assign ctrl_pool   = (state_q != StIdle) && (mode_q == MODE_MAX);
   assign busy        = (state_q == StRun) || (state_q == StDrain);
   assign done        = (state_q == StDone);

endmodule
